// File: rtl/mole_game_core.sv
// rtl/mole_game_core.sv - whack-a-mole game engine for N holes
//
// Purpose: picks a pseudo-random hole, lights its LED for a fixed up-time,
// then scores a correct press as a hit and a wrong press or timeout as a miss.
// The game ends after MAX_MISSES misses.
//
// Ports:
//   clock      system clock, all logic on the rising edge
//   reset      synchronous active-high reset
//   buttons    per-hole level inputs (already synchronised and debounced)
//   start      level; starts a game from IDLE, or restarts one from OVER
//   green      one-hot lit hole, or all zero
//   hit        one-cycle pulse on a correct press
//   miss       one-cycle pulse on a wrong press or a timeout
//   score      hits this game, saturating
//   misses     misses this game
//   game_over  high while the game is over
module mole_game_core #(
  parameter int          N_HOLES    = 4,
  parameter int          TICK_DIV   = 25_000_000,
  parameter int          UP_TICKS   = 3,
  parameter int          GAP_TICKS  = 1,
  parameter int          SCORE_W    = 4,
  parameter int          MAX_MISSES = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [N_HOLES-1:0]              buttons,
  input  logic                            start,
  output logic [N_HOLES-1:0]              green,
  output logic                            hit,
  output logic                            miss,
  output logic [SCORE_W-1:0]              score,
  output logic [$clog2(MAX_MISSES+1)-1:0] misses,
  output logic                            game_over
);

  localparam int HOLE_W = $clog2(N_HOLES);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int PH_MAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int MISS_W = $clog2(MAX_MISSES + 1);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_OVER} state_t;

  state_t              state_q, state_d;
  logic [N_HOLES-1:0]  green_q, green_d;
  logic [N_HOLES-1:0]  buttons_q, buttons_d;
  logic                hit_q, hit_d;
  logic                miss_q, miss_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [MISS_W-1:0]   misses_q, misses_d;
  logic                game_over_q, game_over_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [PH_W-1:0]     phase_cnt_q, phase_cnt_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [HOLE_W-1:0]   hole_q, hole_d;

  logic [N_HOLES-1:0]  btn_edge;
  logic                tick_done;
  logic                gap_done;
  logic                up_done;
  logic [MISS_W-1:0]   misses_inc;
  logic                at_limit;
  logic [HOLE_W-1:0]   sel_raw;
  logic [HOLE_W-1:0]   sel_alt;
  logic [HOLE_W-1:0]   sel;

  function automatic logic [N_HOLES-1:0] onehot(input logic [HOLE_W-1:0] idx);
    logic [N_HOLES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    // Fibonacci LFSR, taps 16,14,13,11
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    buttons_d  = buttons;
    btn_edge   = buttons & ~buttons_q;

    tick_done  = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    gap_done   = tick_done && (phase_cnt_q == PH_W'(GAP_TICKS - 1));
    up_done    = tick_done && (phase_cnt_q == PH_W'(UP_TICKS - 1));
    misses_inc = misses_q + 1'b1;
    at_limit   = (misses_inc == MISS_W'(MAX_MISSES));

    // Never repeat the previous hole: bump to the next one instead
    sel_raw    = HOLE_W'(lfsr_q % 16'(N_HOLES));
    sel_alt    = (sel_raw == HOLE_W'(N_HOLES - 1)) ? '0 : sel_raw + 1'b1;
    sel        = (sel_raw == hole_q) ? sel_alt : sel_raw;

    state_d    = state_q;
    score_d    = score_q;
    misses_d   = misses_q;
    hole_d     = hole_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;

    if (tick_done) begin
      tick_cnt_d  = '0;
      phase_cnt_d = phase_cnt_q + 1'b1;
    end else begin
      tick_cnt_d  = tick_cnt_q + 1'b1;
      phase_cnt_d = phase_cnt_q;
    end

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          score_d  = '0;
          misses_d = '0;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_done) begin
          hole_d  = sel;
          state_d = S_UP;
        end
      end
      S_UP: begin
        if (btn_edge[hole_q]) begin
          hit_d   = 1'b1;
          score_d = (score_q == '1) ? score_q : score_q + 1'b1;
          state_d = S_GAP;
        end else if (|btn_edge) begin
          miss_d   = 1'b1;
          misses_d = misses_inc;
          if (at_limit) begin
            state_d = S_OVER;
          end else if (up_done) begin
            // Wrong press wins this cycle; keep the timer expired so the
            // timeout is taken on the following cycle instead of being lost.
            tick_cnt_d  = tick_cnt_q;
            phase_cnt_d = phase_cnt_q;
          end
        end else if (up_done) begin
          miss_d   = 1'b1;
          misses_d = misses_inc;
          state_d  = at_limit ? S_OVER : S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every phase entry restarts the timer; IDLE and OVER keep it parked at 0
    if ((state_d != state_q) || (state_d == S_IDLE) || (state_d == S_OVER)) begin
      tick_cnt_d  = '0;
      phase_cnt_d = '0;
    end

    green_d     = (state_d == S_UP) ? onehot(hole_d) : '0;
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clock) begin
    buttons_q <= buttons_d;
    if (reset) begin
      state_q     <= S_IDLE;
      green_q     <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      score_q     <= '0;
      misses_q    <= '0;
      game_over_q <= 1'b0;
      tick_cnt_q  <= '0;
      phase_cnt_q <= '0;
      lfsr_q      <= LFSR_SEED;
      hole_q      <= '0;
    end else begin
      state_q     <= state_d;
      green_q     <= green_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      game_over_q <= game_over_d;
      tick_cnt_q  <= tick_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      lfsr_q      <= lfsr_d;
      hole_q      <= hole_d;
    end
  end

  assign green     = green_q;
  assign hit       = hit_q;
  assign miss      = miss_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_mole_game_core.sv
// tb/tb_mole_game_core.sv - self-checking bench for mole_game_core
module tb_mole_game_core;

  localparam int N       = 4;
  localparam int TD      = 4;
  localparam int UPT     = 3;
  localparam int GPT     = 1;
  localparam int SW      = 2;
  localparam int MM      = 3;
  localparam int GAP_CYC = TD * GPT;
  localparam int UP_CYC  = TD * UPT;
  localparam int SMAX    = (1 << SW) - 1;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] buttons;
  logic [N-1:0] green;
  logic         hit;
  logic         miss;
  logic [SW-1:0] score;
  logic [1:0]   misses;
  logic         game_over;

  mole_game_core #(
    .N_HOLES(N), .TICK_DIV(TD), .UP_TICKS(UPT), .GAP_TICKS(GPT),
    .SCORE_W(SW), .MAX_MISSES(MM), .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clock), .reset(reset), .buttons(buttons), .start(start),
    .green(green), .hit(hit), .miss(miss), .score(score),
    .misses(misses), .game_over(game_over)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference random source: the spec's LFSR, stepped every clock from reset
  logic [15:0] m_lfsr, m_lfsr_prev;
  always @(posedge clock) begin
    m_lfsr_prev <= m_lfsr;
    m_lfsr      <= reset ? 16'hACE1 : {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
  end

  int exp_score;
  int exp_misses;
  int exp_hole;
  int up_elapsed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  function automatic int pick(input logic [15:0] l, input int last);
    int s;
    s = int'(l) % N;
    if (s == last) s = (s + 1) % N;
    return s;
  endfunction

  // Called at the first dark cycle; waits for the next mole and checks it
  task automatic wait_mole(input string tag);
    int cnt;
    int h;
    cnt = 0;
    while (green === '0 && cnt < 50) begin
      if (cnt > 0) check({tag, " dark pulses"}, 32'({hit, miss}), 0);
      cnt++;
      step();
    end
    check({tag, " dark length"}, cnt, GAP_CYC);
    check({tag, " not last hole"}, 32'((green >> exp_hole) & 1), 0);
    h = pick(m_lfsr_prev, exp_hole);
    check({tag, " hole"}, 32'(green), 32'(1) << h);
    exp_hole   = h;
    up_elapsed = 1;
  endtask

  task automatic do_hit(input string tag, input int delay, input logic [N-1:0] extra);
    repeat (delay) begin step(); up_elapsed++; end
    buttons = N'(1 << exp_hole) | extra;
    step();
    buttons = '0;
    exp_score = (exp_score + 1 > SMAX) ? SMAX : exp_score + 1;
    check({tag, " hit"}, 32'(hit), 1);
    check({tag, " no miss"}, 32'(miss), 0);
    check({tag, " score"}, 32'(score), exp_score);
    check({tag, " misses"}, 32'(misses), exp_misses);
    check({tag, " green off"}, 32'(green), 0);
    wait_mole(tag);
  endtask

  function automatic int wrong_hole();
    return (exp_hole + 1 + int'($urandom_range(0, N - 2))) % N;
  endfunction

  task automatic do_wrong(input string tag, input int delay);
    repeat (delay) begin step(); up_elapsed++; end
    buttons = N'(1 << wrong_hole());
    step();
    buttons = '0;
    exp_misses++;
    check({tag, " miss"}, 32'(miss), 1);
    check({tag, " no hit"}, 32'(hit), 0);
    check({tag, " misses"}, 32'(misses), exp_misses);
    if (exp_misses == MM) begin
      check({tag, " over green"}, 32'(green), 0);
      check({tag, " game_over"}, 32'(game_over), 1);
    end else begin
      up_elapsed++;
      check({tag, " green kept"}, 32'(green), 32'(1) << exp_hole);
    end
  endtask

  task automatic do_timeout(input string tag);
    while (green !== '0 && up_elapsed < 40) begin
      step();
      if (green !== '0) up_elapsed++;
    end
    check({tag, " up length"}, up_elapsed, UP_CYC);
    exp_misses++;
    check({tag, " miss"}, 32'(miss), 1);
    check({tag, " no hit"}, 32'(hit), 0);
    check({tag, " misses"}, 32'(misses), exp_misses);
    check({tag, " score held"}, 32'(score), exp_score);
    if (exp_misses == MM) check({tag, " game_over"}, 32'(game_over), 1);
    else wait_mole(tag);
  endtask

  task automatic do_start(input string tag);
    buttons = '0;
    start   = 1'b1;
    step();
    start   = 1'b0;
    exp_score  = 0;
    exp_misses = 0;
    check({tag, " score clr"}, 32'(score), 0);
    check({tag, " misses clr"}, 32'(misses), 0);
    check({tag, " game_over clr"}, 32'(game_over), 0);
    wait_mole(tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; buttons = '1;
    exp_score = 0; exp_misses = 0; exp_hole = 0; up_elapsed = 0;
    step(); step();
    check("reset outputs", 32'({green, hit, miss, score, misses, game_over}), 0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      buttons = N'($urandom);
      step();
      check("idle outputs", 32'({green, hit, miss, score, misses, game_over}), 0);
    end

    // Game 1: five hits (saturation), then three timeouts into OVER
    do_start("start1");
    do_hit("hit1", 2, '0);
    for (int i = 0; i < 4; i++) do_hit("hitn", int'($urandom_range(0, 8)), '0);
    for (int i = 0; i < 3; i++) do_timeout("timeout");
    for (int i = 0; i < 10; i++) begin
      buttons = N'($urandom);
      step();
      check("over hold", 32'({green, hit, miss, score, misses, game_over}),
            32'({N'(0), 1'b0, 1'b0, SW'(SMAX), 2'(MM), 1'b1}));
    end

    // Game 2: wrong press then timeout on the same mole, simultaneous press,
    // then a wrong press that ends the game
    do_start("restart");
    do_wrong("wrong1", int'($urandom_range(0, 4)));
    do_timeout("timeout2");
    do_hit("simul", int'($urandom_range(0, 4)), N'(1 << wrong_hole()));
    do_wrong("wrong_end", int'($urandom_range(0, 6)));

    // Game 3: reset in the middle of an up phase
    do_start("restart2");
    repeat (int'($urandom_range(1, 5))) step();
    reset = 1'b1;
    step();
    check("midreset outputs", 32'({green, hit, miss, score, misses, game_over}), 0);
    reset = 1'b0;
    exp_score = 0; exp_misses = 0; exp_hole = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("post reset idle", 32'({green, hit, miss, score, misses, game_over}), 0);
    end
    do_start("after reset");
    do_hit("after reset hit", int'($urandom_range(0, 8)), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
